// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants and types used by the fetch stage and ID.
package mips_pkg;

  localparam logic [31:0] RESET_PC = 32'h0000_3000;
  localparam logic [31:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic {S_FETCH, S_HOLD} fetch_state_e;

  // Primary opcodes and SPECIAL functs that ID decodes into redirects.
  localparam logic [5:0] OP_SPECIAL = 6'h00;
  localparam logic [5:0] OP_J       = 6'h02;
  localparam logic [5:0] OP_JAL     = 6'h03;
  localparam logic [5:0] OP_BEQ     = 6'h04;
  localparam logic [5:0] OP_BNE     = 6'h05;
  localparam logic [5:0] FN_JR      = 6'h08;
  localparam logic [5:0] FN_JALR    = 6'h09;

  function automatic logic [31:0] word_align(input logic [31:0] a);
    return {a[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction-memory request/response bus between fetch (master) and IM (slave).
interface ifu_fetch_if;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;

  modport master (output imem_req, imem_addr, input imem_rvalid, imem_rdata);
  modport slave  (input imem_req, imem_addr, output imem_rvalid, imem_rdata);

endinterface

// File: rtl/ifu_fetch_if_id_reg.sv
// IF/ID pipeline register; hold overrides load and bubble.
module if_id_reg #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        bubble,
  input  logic        hold,
  input  logic [31:0] ir_in,
  input  logic [31:0] pc_in,
  output logic [31:0] IR_D,
  output logic [31:0] PC_D,
  output logic [31:0] PC4_D,
  output logic        valid_D
);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      IR_D    <= NOP_WORD;
      PC_D    <= RESET_PC;
      PC4_D   <= RESET_PC + 32'd4;
      valid_D <= 1'b0;
    end else if (!hold) begin
      if (load) begin
        IR_D    <= ir_in;
        PC_D    <= pc_in;
        PC4_D   <= pc_in + 32'd4;
        valid_D <= 1'b1;
      end else if (bubble) begin
        // bubble keeps the PCs so ID still sees a coherent (if invalid) slot
        IR_D    <= NOP_WORD;
        valid_D <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/ifu_fetch.sv
// MIPS IF stage: PC, IM request FSM, next-PC selection with delay-slot redirect.
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_D,
  input  logic               br_taken_D,
  input  logic [31:0]        br_target_D,
  input  logic               jr_taken_D,
  input  logic [31:0]        jr_target_D,
  ifu_fetch_if.master        imem,
  output logic [31:0]        IR_D,
  output logic [31:0]        PC_D,
  output logic [31:0]        PC4_D,
  output logic               valid_D
);
  import mips_pkg::*;

  fetch_state_e state;
  logic [31:0]  pc_F, pend_pc, ibuf, redir_pc, next_pc;
  logic         pend_v, redirect, deliver, in_fetch, in_hold;

  assign in_fetch = (state == S_FETCH);
  assign in_hold  = (state == S_HOLD);

  assign imem.imem_req  = in_fetch;
  assign imem.imem_addr = pc_F;

  assign redirect = br_taken_D | jr_taken_D;
  assign redir_pc = word_align(jr_taken_D ? jr_target_D : br_target_D);

  // an instruction enters IF/ID this cycle
  assign deliver = !stall_D && (in_hold || (in_fetch && imem.imem_rvalid));

  always_comb begin
    next_pc = pc_F + 32'd4;
    if (pend_v)        next_pc = pend_pc;
    else if (redirect) next_pc = redir_pc;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc_F    <= RESET_PC;
      pend_v  <= 1'b0;
      pend_pc <= 32'h0;
      ibuf    <= NOP_WORD;
    end else begin
      if (deliver) begin
        pc_F   <= next_pc;
        pend_v <= 1'b0;
      end else if (redirect) begin
        // delay slot still in flight: park the target until it is delivered
        pend_v  <= 1'b1;
        pend_pc <= redir_pc;
      end
      case (state)
        S_FETCH: if (imem.imem_rvalid && stall_D) begin
          ibuf  <= imem.imem_rdata;
          state <= S_HOLD;
        end
        S_HOLD:  if (!stall_D) state <= S_FETCH;
        default: state <= S_FETCH;
      endcase
    end
  end

  if_id_reg #(.RESET_PC(RESET_PC), .NOP_WORD(NOP_WORD)) u_if_id (
    .clk     (clk),
    .reset   (reset),
    .load    (in_hold || imem.imem_rvalid),
    .bubble  (in_fetch && !imem.imem_rvalid),
    .hold    (stall_D),
    .ir_in   (in_hold ? ibuf : imem.imem_rdata),
    .pc_in   (pc_F),
    .IR_D    (IR_D),
    .PC_D    (PC_D),
    .PC4_D   (PC4_D),
    .valid_D (valid_D)
  );

  a_br_jr_excl: assert property (@(posedge clk) disable iff (!reset)
    !(br_taken_D && jr_taken_D));
  a_redir_pend: assert property (@(posedge clk) disable iff (!reset)
    !(redirect && pend_v));
  a_rvalid_req: assert property (@(posedge clk) disable iff (!reset)
    !(imem.imem_rvalid && !imem.imem_req));

endmodule

// File: tb/tb_ifu_fetch.sv
// Bench for ifu_fetch: per-cycle vector table, directed latency/reset sequences, random run vs stream model.
module tb_ifu_fetch;
  import mips_pkg::*;

  logic        clk = 1'b0, reset = 1'b0;
  logic        stall_D = 1'b0, br_taken_D = 1'b0, jr_taken_D = 1'b0;
  logic [31:0] br_target_D = 32'h0, jr_target_D = 32'h0;
  logic [31:0] IR_D, PC_D, PC4_D;
  logic        valid_D;

  int tests = 0, fails = 0;
  int fixed_lat = 0;
  bit rand_lat = 1'b0;
  logic [31:0] dmask = 32'h0;
  int wcnt, lat;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk(clk), .reset(reset), .stall_D(stall_D),
    .br_taken_D(br_taken_D), .br_target_D(br_target_D),
    .jr_taken_D(jr_taken_D), .jr_target_D(jr_target_D),
    .imem(bus),
    .IR_D(IR_D), .PC_D(PC_D), .PC4_D(PC4_D), .valid_D(valid_D)
  );

  always #5 clk = ~clk;

  // IM model: word = addr ^ dmask, answered after `lat` wait cycles
  assign bus.imem_rvalid = bus.imem_req && (wcnt >= lat);
  assign bus.imem_rdata  = bus.imem_addr ^ dmask;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wcnt <= 0;
      lat  <= fixed_lat;
    end else if (bus.imem_rvalid || !bus.imem_req) begin
      wcnt <= 0;
      lat  <= rand_lat ? int'($urandom_range(0, 3)) : fixed_lat;
    end else begin
      wcnt <= wcnt + 1;
    end
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, got, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b0; stall_D = 1'b0; br_taken_D = 1'b0; jr_taken_D = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
  endtask

  typedef struct {
    logic        stall, br, jr;
    logic [31:0] tgt;
    logic        req;
    logic [31:0] addr, ir, pc;
    logic        v;
  } vec_t;

  vec_t tbl [11];

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    logic [31:0] exp_next, tgt, t, last;
    bit found, arm, cur_slot, checked;
    int nd, ndeliv;

    // ---------------- table: 0-wait, beq, 2-cycle stall, misaligned jr
    //                 stall br    jr    tgt           req   addr          ir            pc            v
    tbl[0]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3000, 32'h0,    32'h3000, 1'b0};
    tbl[1]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3004, 32'h3000, 32'h3000, 1'b1};
    tbl[2]  = '{1'b0, 1'b1, 1'b0, 32'h3020,     1'b1, 32'h3008, 32'h3004, 32'h3004, 1'b1};
    tbl[3]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3020, 32'h3008, 32'h3008, 1'b1};
    tbl[4]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3024, 32'h3020, 32'h3020, 1'b1};
    tbl[5]  = '{1'b1, 1'b0, 1'b0, 32'h0,        1'b0, 32'h3024, 32'h3020, 32'h3020, 1'b1};
    tbl[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b0, 32'h3024, 32'h3020, 32'h3020, 1'b1};
    tbl[7]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3028, 32'h3024, 32'h3024, 1'b1};
    tbl[8]  = '{1'b0, 1'b0, 1'b1, 32'h3103,     1'b1, 32'h302C, 32'h3028, 32'h3028, 1'b1};
    tbl[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3100, 32'h302C, 32'h302C, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 1'b0, 32'h0,        1'b1, 32'h3104, 32'h3100, 32'h3100, 1'b1};

    fixed_lat = 0; rand_lat = 1'b0; dmask = 32'h0;
    do_reset();
    for (int k = 0; k < 11; k++) begin
      if (k > 0) @(negedge clk);
      chk($sformatf("tbl%0d req", k),  bus.imem_req,  tbl[k].req);
      chk($sformatf("tbl%0d addr", k), bus.imem_addr, tbl[k].addr);
      chk($sformatf("tbl%0d ir", k),   IR_D,          tbl[k].ir);
      chk($sformatf("tbl%0d pc", k),   PC_D,          tbl[k].pc);
      chk($sformatf("tbl%0d pc4", k),  PC4_D,         tbl[k].pc + 32'd4);
      chk($sformatf("tbl%0d valid", k), valid_D,      tbl[k].v);
      stall_D     = tbl[k].stall;
      br_taken_D  = tbl[k].br;
      jr_taken_D  = tbl[k].jr;
      br_target_D = tbl[k].br ? tbl[k].tgt : 32'hDEAD_BEE0;
      jr_target_D = tbl[k].jr ? tbl[k].tgt : 32'h0BAD_F00C;
    end

    // ---------------- PC wrap through 0xFFFF_FFFC
    do_reset();
    @(negedge clk);
    chk("wrap pre pc", PC_D, 32'h3000);
    jr_taken_D = 1'b1; jr_target_D = 32'hFFFF_FFFC;
    @(negedge clk); jr_taken_D = 1'b0;
    chk("wrap slot ir", IR_D, 32'h3004);
    chk("wrap addr", bus.imem_addr, 32'hFFFF_FFFC);
    @(negedge clk);
    chk("wrap top pc", PC_D, 32'hFFFF_FFFC);
    chk("wrap pc4", PC4_D, 32'h0);
    chk("wrap addr0", bus.imem_addr, 32'h0);
    @(negedge clk);
    chk("wrap pc0", PC_D, 32'h0);
    chk("wrap valid", valid_D, 1'b1);

    // ---------------- latency 3, jr while delay slot outstanding
    fixed_lat = 3;
    do_reset();
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      @(negedge clk);
      if (valid_D && PC_D == 32'h3004) found = 1'b1;
    end
    chk("t3 reach 3004", found, 1'b1);
    if (found) begin
      jr_taken_D = 1'b1; jr_target_D = 32'h3104; br_target_D = 32'hDEAD_BEE0;
      @(negedge clk); jr_taken_D = 1'b0;
      chk("t3 pend_v set", dut.pend_v, 1'b1);
      chk("t3 bubble", valid_D, 1'b0);
      found = 1'b0;
      for (int i = 0; i < 10 && !found; i++) begin
        @(negedge clk);
        if (valid_D) found = 1'b1;
      end
      chk("t3 slot arrives", found, 1'b1);
      chk("t3 slot pc", PC_D, 32'h3008);
      chk("t3 slot ir", IR_D, 32'h3008);
      chk("t3 slot pc4", PC4_D, 32'h300C);
      chk("t3 next addr", bus.imem_addr, 32'h3104);
      chk("t3 pend_v clr", dut.pend_v, 1'b0);
    end

    // ---------------- latency 2, bubbles keep PC, delivered PCs step by 4
    fixed_lat = 2;
    do_reset();
    exp_next = RESET_PC; last = RESET_PC; nd = 0;
    for (int i = 0; i < 16; i++) begin
      if (i > 0) @(negedge clk);
      if (valid_D) begin
        chk("t5 pc", PC_D, exp_next);
        chk("t5 ir", IR_D, exp_next);
        last = exp_next; exp_next = exp_next + 32'd4; nd++;
      end else begin
        chk("t5 bubble ir", IR_D, NOP_WORD);
        chk("t5 bubble pc", PC_D, last);
      end
    end
    chk("t5 deliveries", nd >= 4, 1'b1);

    // ---------------- async reset mid-wait, latency 4
    fixed_lat = 4;
    do_reset();
    repeat (12) @(negedge clk);
    @(posedge clk); #2;
    reset = 1'b0;
    #1;
    chk("t6 ir", IR_D, NOP_WORD);
    chk("t6 pc", PC_D, RESET_PC);
    chk("t6 pc4", PC4_D, RESET_PC + 32'd4);
    chk("t6 valid", valid_D, 1'b0);
    chk("t6 addr", bus.imem_addr, RESET_PC);
    @(negedge clk);
    reset = 1'b1;
    chk("t6 rel req", bus.imem_req, 1'b1);
    chk("t6 rel addr", bus.imem_addr, 32'h3000);
    @(negedge clk);
    chk("t6 rel hold addr", bus.imem_addr, 32'h3000);

    // ---------------- random latency/stall/redirect vs instruction-stream model
    rand_lat = 1'b1; fixed_lat = 1; dmask = 32'hC0DE_0000;
    do_reset();
    exp_next = RESET_PC; arm = 1'b0; cur_slot = 1'b0; checked = 1'b0; ndeliv = 0; tgt = 32'h0;
    for (int c = 0; c < 3000; c++) begin
      if (c > 0) @(negedge clk);
      br_taken_D = 1'b0; jr_taken_D = 1'b0;
      if (valid_D && !checked) begin
        chk("rnd pc", PC_D, exp_next);
        chk("rnd ir", IR_D, exp_next ^ dmask);
        chk("rnd pc4", PC4_D, exp_next + 32'd4);
        cur_slot = arm;
        exp_next = arm ? tgt : exp_next + 32'd4;
        arm = 1'b0; checked = 1'b1; ndeliv++;
      end
      if (!valid_D) chk("rnd bubble ir", IR_D, NOP_WORD);
      stall_D = ($urandom_range(0, 3) == 0);
      if (valid_D && !stall_D && !cur_slot && $urandom_range(0, 2) == 0) begin
        t = 32'h3000 + 32'($urandom_range(0, 4095));
        tgt = {t[31:2], 2'b00};
        arm = 1'b1;
        if ($urandom_range(0, 1) == 1) begin
          jr_taken_D = 1'b1; jr_target_D = t; br_target_D = 32'($urandom);
        end else begin
          br_taken_D = 1'b1; br_target_D = t; jr_target_D = 32'($urandom);
        end
      end
      if (!stall_D) checked = 1'b0;
    end
    chk("rnd progress", ndeliv > 500, 1'b1);
    @(negedge clk);
    stall_D = 1'b0; br_taken_D = 1'b0; jr_taken_D = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
